// File: rtl/otg_hpi_pkg.sv
// otg_hpi_pkg: shared types and constants for the CY7C67200 HPI controller.
//   hpi_state_t : bus-cycle sequencer states
//   HPI_DATA/HPI_MAILBOX/HPI_ADDRESS/HPI_STATUS : HPI register selects
//   HPI_CNT_W   : width of the phase timer
package otg_hpi_pkg;

  localparam int HPI_CNT_W = 8;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4,
    RECOVER = 3'd5
  } hpi_state_t;

endpackage

// File: rtl/otg_hpi_timer.sv
// otg_hpi_timer: loadable down-counter shared by every timed HPI phase.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : value to load; a phase lasts load_val+1 cycles
//   zero         : counter is at zero (last cycle of the current phase)
module otg_hpi_timer
  import otg_hpi_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [HPI_CNT_W-1:0] load_val,
  output logic                 zero
);

  logic [HPI_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/otg_hpi_ctrl.sv
// otg_hpi_ctrl: Avalon-MM slave that runs one CY7C67200 HPI read or write
// cycle per Avalon access, with programmable setup/strobe/hold/recovery.
//   clk, reset_n    : clock, asynchronous active-low reset
//   address         : HPI register select (DATA, MAILBOX, ADDRESS, STATUS)
//   read, write     : Avalon requests (write wins when both are high)
//   writedata       : Avalon write data
//   readdata        : captured HPI read data, held until the next read
//   waitrequest     : Avalon stall, low for exactly one cycle per access
//   otg_addr        : HPI address pins
//   otg_cs_n        : HPI chip select
//   otg_rd_n/wr_n   : HPI strobes
//   otg_data_out/oe : pad data and output enable
//   otg_data_in     : pad data in
//   dbg_state       : current sequencer state
// Build option: OTG_HPI_STATUS_FAST_EN makes STATUS reads use the strobe
// phase only (no setup, no hold).
//
// Handshake: a request is accepted when read or write is high in IDLE. The
// master keeps it asserted until it samples waitrequest low; that single
// low cycle completes the transfer. Requests seen outside IDLE are ignored.
module otg_hpi_ctrl
  import otg_hpi_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output hpi_state_t  dbg_state
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255 || STROBE_CYC < 1 || STROBE_CYC > 255 ||
      HOLD_CYC < 0 || HOLD_CYC > 255 || RECOVER_CYC < 0 || RECOVER_CYC > 255) begin : g_bad_timing
    $error("otg_hpi_ctrl: timing parameter out of range");
  end

  // Timer reload values: a phase of N cycles loads N-1.
  localparam logic [HPI_CNT_W-1:0] SETUP_LD   = HPI_CNT_W'(SETUP_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] STROBE_LD  = HPI_CNT_W'(STROBE_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] HOLD_LD    = HPI_CNT_W'(HOLD_CYC - 1);
  localparam logic [HPI_CNT_W-1:0] RECOVER_LD = HPI_CNT_W'(RECOVER_CYC - 1);
  localparam logic HAS_HOLD    = (HOLD_CYC > 0);
  localparam logic HAS_RECOVER = (RECOVER_CYC > 0);

  hpi_state_t           state;
  logic                 is_write;
  logic                 tmr_load;
  logic [HPI_CNT_W-1:0] tmr_val;
  logic                 tmr_zero;
  logic                 accept_fast;  // request being accepted is a fast STATUS read
  logic                 cur_fast;     // access in flight is a fast STATUS read

`ifdef OTG_HPI_STATUS_FAST_EN
  assign accept_fast = !write && (address == HPI_STATUS);
  assign cur_fast    = !is_write && (otg_addr == HPI_STATUS);
`else
  assign accept_fast = 1'b0;
  assign cur_fast    = 1'b0;
`endif

  assign dbg_state = state;

  // Timer reloads coincide with the state transitions below.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: if (read || write) begin
        tmr_load = 1'b1;
        tmr_val  = accept_fast ? STROBE_LD : SETUP_LD;
      end
      SETUP: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = STROBE_LD;
      end
      STROBE: if (tmr_zero && HAS_HOLD && !cur_fast) begin
        tmr_load = 1'b1;
        tmr_val  = HOLD_LD;
      end
      DONE: if (HAS_RECOVER) begin
        tmr_load = 1'b1;
        tmr_val  = RECOVER_LD;
      end
      default: ;
    endcase
  end

  otg_hpi_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      waitrequest  <= 1'b1;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_oe  <= 1'b0;
      otg_addr     <= '0;
      otg_data_out <= '0;
      readdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          waitrequest <= 1'b1;
          if (read || write) begin
            is_write     <= write;
            otg_addr     <= address;
            otg_data_out <= writedata;
            otg_cs_n     <= 1'b0;
            otg_data_oe  <= write;
            if (accept_fast) begin
              otg_rd_n <= 1'b0;
              state    <= STROBE;
            end else begin
              state    <= SETUP;
            end
          end
        end
        SETUP: if (tmr_zero) begin
          otg_wr_n <= !is_write;
          otg_rd_n <= is_write;
          state    <= STROBE;
        end
        STROBE: if (tmr_zero) begin
          otg_rd_n <= 1'b1;
          otg_wr_n <= 1'b1;
          if (!is_write) readdata <= otg_data_in;
          if (HAS_HOLD && !cur_fast) begin
            state <= HOLD;
          end else begin
            waitrequest <= 1'b0;
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
            state       <= DONE;
          end
        end
        HOLD: if (tmr_zero) begin
          waitrequest <= 1'b0;
          otg_cs_n    <= 1'b1;
          otg_data_oe <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          waitrequest <= 1'b1;
          state       <= HAS_RECOVER ? RECOVER : IDLE;
        end
        RECOVER: if (tmr_zero) begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otg_hpi_ctrl.sv
// tb_otg_hpi_ctrl: directed and randomized checks of otg_hpi_ctrl against a
// cycle-count model of one HPI access (phase boundaries computed from the
// timing parameters). Build option OTG_HPI_STATUS_FAST_EN is honoured.
module tb_otg_hpi_ctrl;
  import otg_hpi_pkg::*;

  localparam int S = 1;
  localparam int T = 4;
  localparam int H = 1;
  localparam int R = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read, write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic        otg_cs_n, otg_rd_n, otg_wr_n;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in;
  hpi_state_t  dbg_state;

  always #5 clk = ~clk;

  otg_hpi_ctrl #(
    .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOVER_CYC(R)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
    .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in),
    .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad data: either a fixed value or a fresh random word every cycle.
  logic        din_rand = 1'b0;
  logic [15:0] din_fixed = 16'h0;
  always @(negedge clk) otg_data_in <= din_rand ? 16'($urandom) : din_fixed;

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_c counts clock edges since the accepting edge; each access occupies
  // s setup, T strobe, h hold, one done and R recovery cycles.
  logic        m_busy;
  int          m_c, m_s, m_h;
  logic        m_wr;
  logic [1:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_c <= 0; m_wr <= 1'b0; m_addr <= '0;
      m_wdata <= '0; m_rdata <= '0; m_s <= S; m_h <= H;
    end else if (m_busy) begin
      if (!m_wr && m_c == m_s + T) m_rdata <= otg_data_in;
      if (m_c == m_s + T + m_h + 1 + R) begin
        m_busy <= 1'b0;
        m_c    <= 0;
      end else begin
        m_c <= m_c + 1;
      end
    end else if (read || write) begin
      m_busy  <= 1'b1;
      m_c     <= 1;
      m_wr    <= write;
      m_addr  <= address;
      m_wdata <= writedata;
      m_s     <= S;
      m_h     <= H;
`ifdef OTG_HPI_STATUS_FAST_EN
      if (!write && address == 2'd3) begin
        m_s <= 0;
        m_h <= 0;
      end
`endif
    end
  end

  logic e_cs_n, e_strobe, e_wait, e_oe;
  assign e_cs_n   = !(m_busy && m_c <= m_s + T + m_h);
  assign e_strobe = m_busy && m_c > m_s && m_c <= m_s + T;
  assign e_wait   = !(m_busy && m_c == m_s + T + m_h + 1);
  assign e_oe     = m_busy && m_wr && m_c <= m_s + T + m_h;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cs_n", 32'(otg_cs_n), 32'(e_cs_n));
      chk("rd_n", 32'(otg_rd_n), 32'(!(e_strobe && !m_wr)));
      chk("wr_n", 32'(otg_wr_n), 32'(!(e_strobe && m_wr)));
      chk("waitrequest", 32'(waitrequest), 32'(e_wait));
      chk("data_oe", 32'(otg_data_oe), 32'(e_oe));
      chk("otg_addr", 32'(otg_addr), 32'(m_addr));
      chk("data_out", 32'(otg_data_out), 32'(m_wdata));
      chk("readdata", 32'(readdata), 32'(m_rdata));
    end
  end

  // ---------------- driver ----------------
  int cs_lo, rd_lo, wr_lo, oe_hi, first_cs, first_rd, first_wr, done_cyc;

  // Called just after a rising edge; returns just after the edge that
  // completes the transfer, with the request dropped.
  task automatic access(input logic r, input logic w, input logic [1:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rv);
    int k0, n;
    logic done;
    read = r; write = w; address = a; writedata = d;
    k0 = cyc;
    n = 0; done = 1'b0;
    cs_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0;
    first_cs = -1; first_rd = -1; first_wr = -1;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (!otg_cs_n) begin cs_lo++; if (first_cs < 0) first_cs = cyc; end
      if (!otg_rd_n) begin rd_lo++; if (first_rd < 0) first_rd = cyc; end
      if (!otg_wr_n) begin wr_lo++; if (first_wr < 0) first_wr = cyc; end
      if (otg_data_oe) oe_hi++;
      if (!waitrequest) done = 1'b1;
    end
    if (!done) chk("access_timeout", 32'(done), 32'd1);
    done_cyc = cyc;
    lat = cyc - (k0 + 1);
    rv = readdata;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (R + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, d1, n, kind, gap;
    logic [15:0] rv;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_waitrequest", 32'(waitrequest), 32'd1);
    chk("rst_cs_n", 32'(otg_cs_n), 32'd1);
    chk("rst_rd_wr_n", {30'd0, otg_rd_n, otg_wr_n}, 32'd3);
    chk("rst_oe", 32'(otg_data_oe), 32'd0);
    chk("rst_readdata", 32'(readdata), 32'd0);
    chk("rst_addr_dout", {14'd0, otg_addr, otg_data_out}, 32'd0);
    chk_en = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Write 0xBEEF to ADDRESS register.
    access(1'b0, 1'b1, 2'd2, 16'hBEEF, lat, rv);
    chk("wr_latency", 32'(lat), 32'd6);
    chk("wr_cs_cycles", 32'(cs_lo), 32'd6);
    chk("wr_strobe_cycles", 32'(wr_lo), 32'd4);
    chk("wr_no_rd", 32'(rd_lo), 32'd0);
    chk("wr_strobe_offset", 32'(first_wr - first_cs), 32'd1);
    chk("wr_dout", 32'(otg_data_out), 32'hBEEF);
    idle_wait();

    // Read DATA register with fixed pad data.
    din_fixed = 16'h1234;
    access(1'b1, 1'b0, 2'd0, 16'h0000, lat, rv);
    chk("rd_latency", 32'(lat), 32'd6);
    chk("rd_data", 32'(rv), 32'h1234);
    chk("rd_oe_low", 32'(oe_hi), 32'd0);
    chk("rd_strobe_cycles", 32'(rd_lo), 32'd4);
    idle_wait();

    // read and write together: write wins.
    access(1'b1, 1'b1, 2'd1, 16'h00AA, lat, rv);
    chk("both_wr_cycles", 32'(wr_lo), 32'd4);
    chk("both_no_rd", 32'(rd_lo), 32'd0);
    chk("both_oe_cycles", 32'(oe_hi), 32'd6);
    chk("both_dout", 32'(otg_data_out), 32'h00AA);
    idle_wait();

    // Back-to-back writes: recovery spacing.
    access(1'b0, 1'b1, 2'd2, 16'h1111, lat, rv);
    d1 = done_cyc;
    access(1'b0, 1'b1, 2'd0, 16'h2222, lat, rv);
    chk("b2b_gap_ok", 32'((first_cs - d1) >= R + 1), 32'd1);
    idle_wait();

    // STATUS read.
    din_fixed = 16'h0055;
    access(1'b1, 1'b0, 2'd3, 16'h0000, lat, rv);
    chk("status_data", 32'(rv), 32'h0055);
`ifdef OTG_HPI_STATUS_FAST_EN
    chk("status_latency", 32'(lat), 32'd4);
    chk("status_rd_with_cs", 32'(first_rd - first_cs), 32'd0);
`else
    chk("status_latency", 32'(lat), 32'd6);
    chk("status_rd_after_cs", 32'(first_rd - first_cs), 32'd1);
`endif
    idle_wait();

    // Reset during the write strobe.
    write = 1'b1; address = 2'd0; writedata = 16'h5A5A;
    n = 0;
    while (otg_wr_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_strobe", 32'(otg_wr_n), 32'd0);
    #2;
    reset_n = 1'b0;
    write = 1'b0;
    #1;
    chk("rst_mid_cs_n", 32'(otg_cs_n), 32'd1);
    chk("rst_mid_wr_n", 32'(otg_wr_n), 32'd1);
    chk("rst_mid_oe", 32'(otg_data_oe), 32'd0);
    chk("rst_mid_waitrequest", 32'(waitrequest), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    din_fixed = 16'hC0DE;
    access(1'b1, 1'b0, 2'd0, 16'h0000, lat, rv);
    chk("post_rst_latency", 32'(lat), 32'd6);
    chk("post_rst_data", 32'(rv), 32'hC0DE);

    // Randomized traffic, including back-to-back requests and bus noise
    // on address/writedata between accesses.
    din_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        address = 2'($urandom_range(0, 3));
        writedata = 16'($urandom);
        @(posedge clk);
        #1;
      end
      kind = $urandom_range(0, 2);
      access(kind != 1, kind != 0, 2'($urandom_range(0, 3)), 16'($urandom), lat, rv);
    end
    din_rand = 1'b0;
    idle_wait();
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
